// File: rtl/cla_seq_adder32_if.sv
// Bus bundle for the sequential carry look-ahead add/subtract unit.
//   start/op_sub/a/b : request side, driven by the ALU-control logic (master)
//   busy/done        : status back to the requester
//   result/co/ovf    : sum or difference, carry out of the MSB, signed overflow
// The adder itself attaches through the slave modport.
interface cla_seq_adder32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, co, ovf
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, co, ovf
  );
endinterface

// File: rtl/cla_seq_adder32.sv
// Multi-cycle add/subtract unit built around one 4-bit carry look-ahead slice.
// The slice is reused for WIDTH/4 cycles, least significant nibble first, with
// the inter-nibble carry held in a register between cycles.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; returns every register to zero / IDLE
//   bus    : slave side of cla_seq_adder32_if
//            start/op_sub/a/b sampled only in IDLE or DONE
//            busy high during RUN, done a one-cycle pulse in DONE
//            result/co/ovf updated only on the final RUN edge, held otherwise
module cla_seq_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cla_seq_adder32_if.slave      bus
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_seq_adder32: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         nib_a, nib_b, nib_s;
  logic               slice_c3, slice_co;
  logic               accept;
  logic               last;

  // 4-bit carry look-ahead slice. Returns {carry_out, carry_into_bit3, sum}.
  // Carry into bit 3 is exported so the final nibble can form signed overflow.
  function automatic logic [5:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    logic [3:0] s;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
    return {c4, c3, s};
  endfunction

  // Slice datapath: select the current nibble of each operand.
  always_comb begin
    nib_a = opa_q[4*int'(cnt_q) +: 4];
    nib_b = opb_q[4*int'(cnt_q) +: 4];
    {slice_co, slice_c3, nib_s} = cla4(nib_a, nib_b, carry_q);
  end

  assign last   = (cnt_q == CNT_W'(NIB - 1));
  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    work_d   = work_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        work_d[4*int'(cnt_q) +: 4] = nib_s;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // Outputs are published only once the whole word is assembled, so the
        // final nibble is merged straight into the visible result here.
        if (last) begin
          state_d  = DONE;
          result_d = work_d;
          co_d     = slice_co;
          ovf_d    = slice_c3 ^ slice_co;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
    if (accept) begin
      state_d = RUN;
      opa_d   = bus.a;
      opb_d   = bus.op_sub ? ~bus.b : bus.b;
      carry_d = bus.op_sub;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      work_q   <= work_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder32.sv
module tb_cla_seq_adder32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  cla_seq_adder32_if #(.WIDTH(32)) bus ();

  cla_seq_adder32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, scramble the inputs after the accept edge, and wait
  // (bounded) for done. lat counts cycles from the accept edge; 9 is expected.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       output logic [31:0] r, output logic rco, output logic rovf,
                       output int lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_sub = ts; bus.a = ta; bus.b = tb_v;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_sub = ~ts; bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result; rco = bus.co; rovf = bus.ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if ({bus.co, bus.ovf} !== 2'b00) begin errors++; $display("FAIL reset_co_ovf got %b want 00", {bus.co, bus.ovf}); end
    // reset and start together: reset wins
    bus.start = 1'b1; bus.a = 32'h1; bus.b = 32'h1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_wins busy got %b want 0", bus.busy); end
    bus.start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_increment_wrap();
    logic [31:0] r; logic c, v; int lat;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, r, c, v, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL wrap_latency got %0d want 9", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL wrap_result got %h want 00000000", r); end
    checks++; if ({c, v} !== 2'b10) begin errors++; $display("FAIL wrap_co_ovf got %b want 10", {c, v}); end
    @(posedge clk); #1;
    checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL wrap_done_once done/busy got %b want 00", {bus.done, bus.busy}); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL wrap_hold got %h want 00000000", bus.result); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic c, v; int lat;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, r, c, v, lat);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL posovf_result got %h want 80000000", r); end
    checks++; if ({c, v} !== 2'b01) begin errors++; $display("FAIL posovf_co_ovf got %b want 01", {c, v}); end
    do_op(32'h80000000, 32'h80000000, 1'b0, r, c, v, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL negovf_result got %h want 00000000", r); end
    checks++; if ({c, v} !== 2'b11) begin errors++; $display("FAIL negovf_co_ovf got %b want 11", {c, v}); end
  endtask

  task automatic test_subtract();
    logic [31:0] r; logic c, v; int lat;
    do_op(32'd5, 32'd7, 1'b1, r, c, v, lat);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_borrow_result got %h want fffffffe", r); end
    checks++; if ({c, v} !== 2'b00) begin errors++; $display("FAIL sub_borrow_co_ovf got %b want 00", {c, v}); end
    do_op(32'd7, 32'd5, 1'b1, r, c, v, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL sub_result got %h want 00000002", r); end
    checks++; if ({c, v} !== 2'b10) begin errors++; $display("FAIL sub_co_ovf got %b want 10", {c, v}); end
  endtask

  task automatic test_ripple_ignore_start();
    int lat;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 32'h0FFFFFFF; bus.b = 32'h00000001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (lat == 3) begin
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.a = 32'h55555555; bus.b = 32'h11111111;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    checks++; if (lat !== 9) begin errors++; $display("FAIL ripple_latency got %0d want 9", lat); end
    checks++; if (bus.result !== 32'h10000000) begin errors++; $display("FAIL ripple_result got %h want 10000000", bus.result); end
    checks++; if ({bus.co, bus.ovf} !== 2'b00) begin errors++; $display("FAIL ripple_co_ovf got %b want 00", {bus.co, bus.ovf}); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 32'h12345678; bus.b = 32'h11111111;
    @(posedge clk); #1;
    bus.op_sub = 1'b1; bus.a = 32'h23456789; bus.b = 32'h11111111;
    lat = 1;
    while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", lat); end
    checks++; if (bus.result !== 32'h23456789) begin errors++; $display("FAIL b2b_first_result got %h want 23456789", bus.result); end
    checks++; if (bus.co !== 1'b0) begin errors++; $display("FAIL b2b_first_co got %b want 0", bus.co); end
    gap = 1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept busy got %b want 1", bus.busy); end
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    while (!bus.done && gap < 20) begin @(posedge clk); #1; gap++; end
    checks++; if (gap !== 9) begin errors++; $display("FAIL b2b_period got %0d want 9", gap); end
    checks++; if (bus.result !== 32'h12345678) begin errors++; $display("FAIL b2b_second_result got %h want 12345678", bus.result); end
    checks++; if ({bus.co, bus.ovf} !== 2'b10) begin errors++; $display("FAIL b2b_second_co_ovf got %b want 10", {bus.co, bus.ovf}); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic c, v; int lat; int seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL midrst_busy_done got %b want 00", {bus.busy, bus.done}); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h want 00000000", bus.result); end
    checks++; if ({bus.co, bus.ovf} !== 2'b00) begin errors++; $display("FAIL midrst_co_ovf got %b want 00", {bus.co, bus.ovf}); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
    do_op(32'd3, 32'd4, 1'b0, r, c, v, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL midrst_restart_latency got %0d want 9", lat); end
    checks++; if ({r, c, v} !== {32'h7, 2'b00}) begin errors++; $display("FAIL midrst_restart got %h/%b%b want 00000007/00", r, c, v); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_increment_wrap();
    test_overflow();
    test_subtract();
    test_ripple_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
